// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle for the bit-serial adder: operand request side and result side.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell (two half adders) reused LSB-first over WIDTH
// clocks, with valid/ready handshakes on operands and on the held result.
module halfAdder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   serial_add_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic [WIDTH-1:0] sum_q;
   logic             c;
   logic             cout_q;
   logic [CNT_W-1:0] cnt;
   logic             hs0;
   logic             hc0;
   logic             hs1;
   logic             hc1;
   logic             bit_s;
   logic             bit_co;
   logic             last_bit;

   halfAdder ha0 (.x(sa[0]), .y(sb[0]), .s(hs0), .c(hc0));
   halfAdder ha1 (.x(hs0),   .y(c),     .s(hs1), .c(hc1));

   assign bit_s    = hs1;
   assign bit_co   = hc0 | hc1;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // The result register fills from the MSB end so the LSB-first bits land in place.
   generate
      if (WIDTH == 1) begin : g_sr_one
         assign sr_next = bit_s;
      end else begin : g_sr_many
         assign sr_next = {bit_s, sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_next = RUN;
         RUN:     if (last_bit)      state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operands sampled only at accept; outputs only move at the completion edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sa  <= bus.a;
                  sb  <= bus.b;
                  c   <= bus.cin;
                  cnt <= '0;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sr  <= sr_next;
               c   <= bit_co;
               cnt <= cnt + 1'b1;
               if (last_bit) begin
                  sum_q  <= sr_next;
                  cout_q <= bit_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed corner cases plus a randomized
// stream scored against plain a+b+cin arithmetic.
module tb_serial_add_ctrl;
   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic ci);
      return {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(ci);
   endfunction

   task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                input logic opC, output int lat);
      bus.a        = opA;
      bus.b        = opB;
      bus.cin      = opC;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.a = 8'hA5;
      bus.b = 8'h5A;
      tick();
      tick();
      bus.in_valid = 1'b0;
      total++;
      if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL reset_flags got rdy/ov/busy=%b want 100", {bus.in_ready, bus.out_valid, bus.busy});
      end
      total++;
      if ({bus.cout, bus.sum} !== 9'h000) begin
         bad++;
         $display("[TB] FAIL reset_result got %h want 000", {bus.cout, bus.sum});
      end
      rst = 1'b0;
      tick();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_no_start busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_basic();
      int lat;
      logic [WIDTH:0] exp;
      bus.out_ready = 1'b1;
      exp = model(8'h5A, 8'h33, 1'b0);
      applyStimulus(8'h5A, 8'h33, 1'b0, lat);
      total++;
      if (lat !== WIDTH) begin
         bad++;
         $display("[TB] FAIL basic_latency got %0d want %0d", lat, WIDTH);
      end
      total++;
      if ({bus.cout, bus.sum} !== exp) begin
         bad++;
         $display("[TB] FAIL basic_sum got %h want %h", {bus.cout, bus.sum}, exp);
      end
      tick();
      total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL basic_after ov/rdy got %b want 01", {bus.out_valid, bus.in_ready});
      end
   endtask

   task automatic test_carry();
      logic [WIDTH-1:0] va [3];
      logic [WIDTH-1:0] vb [3];
      logic             vc [3];
      int lat;
      logic [WIDTH:0] exp;
      va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0;
      va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1;
      va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp = model(va[i], vb[i], vc[i]);
         applyStimulus(va[i], vb[i], vc[i], lat);
         total++;
         if ({bus.cout, bus.sum} !== exp || lat !== WIDTH) begin
            bad++;
            $display("[TB] FAIL carry_%0d got %h lat %0d want %h lat %0d", i, {bus.cout, bus.sum}, lat, exp, WIDTH);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [WIDTH:0] exp;
      exp = model(8'hC3, 8'h7E, 1'b1);
      bus.out_ready = 1'b0;
      applyStimulus(8'hC3, 8'h7E, 1'b1, lat);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.a   = WIDTH'($urandom);
         bus.b   = WIDTH'($urandom);
         bus.cin = 1'($urandom);
         tick();
         total++;
         if ({bus.out_valid, bus.in_ready} !== 2'b10 || {bus.cout, bus.sum} !== exp) begin
            bad++;
            $display("[TB] FAIL bp_hold_%0d ov/rdy %b res %h want 10 res %h", i,
                     {bus.out_valid, bus.in_ready}, {bus.cout, bus.sum}, exp);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01 || {bus.cout, bus.sum} !== exp) begin
         bad++;
         $display("[TB] FAIL bp_release ov/rdy %b res %h want 01 res %h",
                  {bus.out_valid, bus.in_ready}, {bus.cout, bus.sum}, exp);
      end
   endtask

   task automatic test_reset_midrun();
      int lat;
      int seen;
      logic [WIDTH:0] exp;
      bus.out_ready = 1'b1;
      bus.a = 8'h5A;
      bus.b = 8'h33;
      bus.cin = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({bus.busy, bus.out_valid, bus.cout, bus.sum} !== 11'h000) begin
         bad++;
         $display("[TB] FAIL midrun_abort busy/ov/res got %h want 000", {bus.busy, bus.out_valid, bus.cout, bus.sum});
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("[TB] FAIL midrun_no_valid got %0d valid cycles want 0", seen);
      end
      exp = model(8'h10, 8'h20, 1'b1);
      applyStimulus(8'h10, 8'h20, 1'b1, lat);
      total++;
      if ({bus.cout, bus.sum} !== exp || lat !== WIDTH) begin
         bad++;
         $display("[TB] FAIL midrun_next got %h lat %0d want %h lat %0d", {bus.cout, bus.sum}, lat, exp, WIDTH);
      end
      tick();
   endtask

   task automatic test_streaming();
      logic [WIDTH:0] q[$];
      logic [WIDTH:0] exp;
      int cycle;
      int accepts;
      int lastAccept;
      int limit;
      limit = 100 * (WIDTH + 2) + 60;
      accepts = 0;
      lastAccept = -1;
      cycle = 0;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      while ((accepts < 100 || q.size() != 0) && cycle < limit) begin
         bus.a   = WIDTH'($urandom);
         bus.b   = WIDTH'($urandom);
         bus.cin = 1'($urandom);
         bus.in_valid = (accepts < 100);
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.a, bus.b, bus.cin));
            if (lastAccept >= 0) begin
               total++;
               if (cycle - lastAccept !== WIDTH + 2) begin
                  bad++;
                  $display("[TB] FAIL stream_spacing got %0d want %0d", cycle - lastAccept, WIDTH + 2);
               end
            end
            lastAccept = cycle;
            accepts++;
         end
         tick();
         cycle++;
         if (bus.out_valid) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("[TB] FAIL stream_extra got %h want none", {bus.cout, bus.sum});
            end else begin
               exp = q.pop_front();
               if ({bus.cout, bus.sum} !== exp) begin
                  bad++;
                  $display("[TB] FAIL stream_result got %h want %h", {bus.cout, bus.sum}, exp);
               end
            end
         end
      end
      bus.in_valid = 1'b0;
      total++;
      if (accepts !== 100 || q.size() !== 0) begin
         bad++;
         $display("[TB] FAIL stream_scoreboard accepts %0d left %0d want 100 left 0", accepts, q.size());
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_reset_midrun();
      test_streaming();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-multiplexes a single 1-bit adder cell across the bits of a WIDTH-bit addition.
- The 1-bit cell is two halfAdder instances plus an OR for carry-out.
- Accepts operands through a valid/ready handshake and runs the cell one bit per clock, LSB first, with a registered carry.
- Presents the completed sum and carry-out through a valid/ready output handshake.
- Serves as the low-area add unit in front of the existing combinational adder cells.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a, b, cin valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum/cout hold a completed result
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits [WIDTH-1:0] of a+b+cin
- cout  output  1  result bit WIDTH of a+b+cin
- busy  output  1  state is not IDLE

Behaviour:
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE). All three are decoded from registered state.

IDLE:
- On in_valid && in_ready at edge E0:
  - load shift regs sa<=a, sb<=b;
  - carry reg c<=cin;
  - bit counter cnt<=0;
  - go to RUN.
- Otherwise stay in IDLE.

RUN:
- Each edge:
  - bit cell computes s = sa[0]^sb[0]^c and co = (sa[0]&sb[0]) | ((sa[0]^sb[0])&c);
  - sa, sb shift right by 1;
  - s shifts into the MSB of the result shift reg sr (sr shifts right);
  - c<=co; cnt<=cnt+1.
- At the edge where cnt==WIDTH-1 (the WIDTH-th bit):
  - sum<=final sr value, including this bit;
  - cout<=co;
  - go to DONE.

Latency and throughput:
- out_valid rises exactly WIDTH cycles after E0.
- With out_ready held high, the next operand is accepted WIDTH+2 cycles after E0.

DONE:
- sum and cout are held stable.
- in_ready=0; in_valid is ignored.
- On out_valid && out_ready, go to IDLE at that edge.
- Backpressure is unbounded.

Output hold:
- sum and cout change only at the completion edge or on reset.
- They keep the last result after returning to IDLE.
- Internal sa/sb/sr/c are never visible on the outputs.

Input sampling:
- a, b, cin are sampled only at the accept edge.
- Changes during RUN or DONE have no effect.

WIDTH=1:
- RUN lasts one cycle.
- sum = a^b^cin, cout = majority(a, b, cin).

Reset (synchronous, evaluated every edge, dominates all other conditions):
- state<=IDLE, cnt<=0, c<=0, sa/sb/sr<=0, sum<=0, cout<=0.
- After reset: out_valid=0, busy=0, in_ready=1.
- Reset asserted in RUN or DONE aborts the operation. No out_valid is produced and the pending result is discarded.
- Reset coinciding with an input or output handshake: the handshake is not taken.

Arithmetic:
- {cout, sum} equals a + b + cin, computed modulo 2^(WIDTH+1).
- No overflow flag.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0. No operation is started.
- WIDTH=8: a=0x5A, b=0x33, cin=0, out_ready=1 -> out_valid high exactly 8 cycles after accept, sum=0x8D, cout=0, out_valid high for 1 cycle, then in_ready=1.
- Carry ripple:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and a/b toggling -> out_valid, sum and cout stable; in_ready=0; then out_ready=1 -> IDLE next cycle, and sum is still held.
- Reset mid-RUN: a=0x5A, b=0x33, rst pulsed on the 4th RUN cycle -> no out_valid, sum=0x00. Then a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0.
- Streaming: in_valid=1 and out_ready=1 constantly, with 100 random a/b/cin and a changed during RUN -> accepts spaced exactly WIDTH+2 cycles apart, every result matches a+b+cin, scoreboard is clean.
